// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory access path.
// Used by the access controller and the writeback load extractor.
package mem_pkg;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   localparam logic [1:0] EXC_NONE = 2'b00;
   localparam logic [1:0] EXC_ADDR = 2'b01;
   localparam logic [1:0] EXC_BUS  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_t;

   function automatic logic is_store(input logic [2:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] op,
                                          input logic [1:0] a1_0);
      logic half;
      logic word;
      half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      word = (op == OP_LW) || (op == OP_SW);
      return (half && a1_0[0]) || (word && (a1_0 != 2'b00));
   endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane select plus sign/zero extension of load data.
// Purely combinational so the writeback stage can reuse it.
module load_extract
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  op,
   output logic [31:0] value
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[7:0];
      case (offset)
         2'd0: byte_v = rdata[7:0];
         2'd1: byte_v = rdata[15:8];
         2'd2: byte_v = rdata[23:16];
         2'd3: byte_v = rdata[31:24];
         default: byte_v = rdata[7:0];
      endcase
      half_v = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      value = rdata;
      case (op)
         OP_LB:   value = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  value = {24'd0, byte_v};
         OP_LH:   value = {{16{half_v[15]}}, half_v};
         OP_LHU:  value = {16'd0, half_v};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one load/store at a time against a variable-latency
// data memory, with alignment and bus-timeout exceptions.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_exc
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic [3:0]  fmt_we;
   logic [31:0] fmt_wdata;
   logic [31:0] ld_value;

   always_comb begin
      fmt_we    = 4'b0000;
      fmt_wdata = 32'd0;
      case (req_op)
         OP_SB: begin
            fmt_we    = 4'b0001 << req_addr[1:0];
            fmt_wdata = {4{req_wdata[7:0]}};
         end
         OP_SH: begin
            fmt_we    = 4'b0011 << req_addr[1:0];
            fmt_wdata = {2{req_wdata[15:0]}};
         end
         OP_SW: begin
            fmt_we    = 4'b1111;
            fmt_wdata = req_wdata;
         end
         default: begin
            fmt_we    = 4'b0000;
            fmt_wdata = 32'd0;
         end
      endcase
   end

   load_extract u_load_extract (
      .rdata  (mem_rdata),
      .offset (off_q),
      .op     (op_q),
      .value  (ld_value)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= 8'd0;
         op_q       <= OP_LB;
         off_q      <= 2'b00;
         req_ready  <= 1'b1;
         mem_en     <= 1'b0;
         mem_we     <= 4'b0000;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_exc   <= EXC_NONE;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  off_q     <= req_addr[1:0];
                  cnt       <= 8'd0;
                  req_ready <= 1'b0;
                  if (is_misaligned(req_op, req_addr[1:0])) begin
                     state      <= ST_DONE;
                     resp_valid <= 1'b1;
                     resp_rdata <= 32'd0;
                     resp_exc   <= EXC_ADDR;
                  end else begin
                     state     <= ST_ACCESS;
                     mem_en    <= 1'b1;
                     mem_we    <= fmt_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= fmt_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               // An ack on the expiring cycle still wins over the timeout.
               if (mem_ack) begin
                  state      <= ST_DONE;
                  mem_en     <= 1'b0;
                  mem_we     <= 4'b0000;
                  resp_valid <= 1'b1;
                  resp_exc   <= EXC_NONE;
                  resp_rdata <= is_store(op_q) ? 32'd0 : ld_value;
               end else if (cnt == CNT_LAST) begin
                  state      <= ST_DONE;
                  mem_en     <= 1'b0;
                  mem_we     <= 4'b0000;
                  resp_valid <= 1'b1;
                  resp_exc   <= EXC_BUS;
                  resp_rdata <= 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               cnt       <= 8'd0;
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               mem_en    <= 1'b0;
               mem_we    <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, alignment,
// timeout and reset-abort, with a short-timeout second instance.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_valid_to;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        req_ready, mem_en, resp_valid;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, resp_rdata;
   logic [1:0]  resp_exc;

   logic        req_ready_to, mem_en_to, resp_valid_to;
   logic [3:0]  mem_we_to;
   logic [31:0] mem_addr_to, mem_wdata_to, resp_rdata_to;
   logic [1:0]  resp_exc_to;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_exc   (resp_exc)
   );

   mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid_to),
      .req_ready  (req_ready_to),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_en     (mem_en_to),
      .mem_we     (mem_we_to),
      .mem_addr   (mem_addr_to),
      .mem_wdata  (mem_wdata_to),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .resp_valid (resp_valid_to),
      .resp_rdata (resp_rdata_to),
      .resp_exc   (resp_exc_to)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      req_valid_to = 1'b0;
      req_op = 3'b000;
      req_addr = 32'd0;
      req_wdata = 32'd0;
      mem_rdata = 32'd0;
      mem_ack = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      tests++;
      if (req_ready !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'b0000 ||
          mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         fails++;
         $display("FAIL reset_mem: ready=%b en=%b we=%b addr=%h wd=%h want 1 0 0000 0 0",
                  req_ready, mem_en, mem_we, mem_addr, mem_wdata);
      end
      tests++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_exc !== 2'b00) begin
         fails++;
         $display("FAIL reset_resp: valid=%b rdata=%h exc=%b want 0 0 00",
                  resp_valid, resp_rdata, resp_exc);
      end
   endtask

   task automatic test_lb_fast();
      req_valid = 1'b1;
      req_op = 3'b000;
      req_addr = 32'h0000_1003;
      cyc();
      req_valid = 1'b0;
      tests++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_we !== 4'b0000 ||
          req_ready !== 1'b0) begin
         fails++;
         $display("FAIL lb_issue: en=%b addr=%h we=%b ready=%b want 1 00001000 0000 0",
                  mem_en, mem_addr, mem_we, req_ready);
      end
      mem_rdata = 32'h80FF_1234;
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80 || resp_exc !== 2'b00 ||
          mem_en !== 1'b0) begin
         fails++;
         $display("FAIL lb_resp: valid=%b rdata=%h exc=%b en=%b want 1 ffffff80 00 0",
                  resp_valid, resp_rdata, resp_exc, mem_en);
      end
      cyc();
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fails++;
         $display("FAIL lb_done: valid=%b ready=%b want 0 1", resp_valid, req_ready);
      end
   endtask

   task automatic test_lhu_slow();
      bit stable = 1'b1;
      req_valid = 1'b1;
      req_op = 3'b011;
      req_addr = 32'h0000_2002;
      cyc();
      req_valid = 1'b0;
      mem_rdata = 32'hBEEF_0000;
      for (int i = 0; i < 5; i++) begin
         if (mem_en !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_we !== 4'b0000 ||
             resp_valid !== 1'b0)
            stable = 1'b0;
         if (i == 4) mem_ack = 1'b1;
         cyc();
      end
      mem_ack = 1'b0;
      tests++;
      if (!stable) begin
         fails++;
         $display("FAIL lhu_hold: stable=%b want 1", stable);
      end
      tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_BEEF || resp_exc !== 2'b00) begin
         fails++;
         $display("FAIL lhu_resp: valid=%b rdata=%h exc=%b want 1 0000beef 00",
                  resp_valid, resp_rdata, resp_exc);
      end
      cyc();
   endtask

   task automatic test_loads();
      logic [2:0]  ops[6]  = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b000, 3'b011};
      logic [31:0] adr[6]  = '{32'h6000, 32'h7001, 32'h7004, 32'h6002, 32'h7002, 32'h6000};
      logic [31:0] rd[6]   = '{32'h1234_8001, 32'h0000_9A00, 32'hDEAD_BEEF,
                               32'h7FFF_0000, 32'h007F_0000, 32'h1234_8001};
      logic [31:0] exp[6]  = '{32'hFFFF_8001, 32'h0000_009A, 32'hDEAD_BEEF,
                               32'h0000_7FFF, 32'h0000_007F, 32'h0000_8001};
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_op = ops[i];
         req_addr = adr[i];
         cyc();
         req_valid = 1'b0;
         mem_rdata = rd[i];
         mem_ack = 1'b1;
         cyc();
         mem_ack = 1'b0;
         tests++;
         if (resp_valid !== 1'b1 || resp_rdata !== exp[i] || resp_exc !== 2'b00) begin
            fails++;
            $display("FAIL load_%0d: valid=%b rdata=%h exc=%b want 1 %h 00",
                     i, resp_valid, resp_rdata, resp_exc, exp[i]);
         end
         cyc();
      end
   endtask

   task automatic test_stores();
      logic [2:0]  ops[3] = '{3'b110, 3'b101, 3'b111};
      logic [31:0] adr[3] = '{32'h3002, 32'h5001, 32'h5008};
      logic [31:0] wd[3]  = '{32'h0000_ABCD, 32'h1234_5677, 32'hCAFE_F00D};
      logic [3:0]  ewe[3] = '{4'b1100, 4'b0010, 4'b1111};
      logic [31:0] ewd[3] = '{32'hABCD_ABCD, 32'h7777_7777, 32'hCAFE_F00D};
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_op = ops[i];
         req_addr = adr[i];
         req_wdata = wd[i];
         cyc();
         req_valid = 1'b0;
         req_wdata = 32'h0;
         tests++;
         if (mem_en !== 1'b1 || mem_we !== ewe[i] || mem_wdata !== ewd[i] ||
             mem_addr !== {adr[i][31:2], 2'b00}) begin
            fails++;
            $display("FAIL store_lane_%0d: en=%b we=%b wd=%h addr=%h want 1 %b %h",
                     i, mem_en, mem_we, mem_wdata, mem_addr, ewe[i], ewd[i]);
         end
         mem_rdata = 32'hFFFF_FFFF;
         mem_ack = 1'b1;
         cyc();
         mem_ack = 1'b0;
         tests++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'd0 || resp_exc !== 2'b00) begin
            fails++;
            $display("FAIL store_resp_%0d: valid=%b rdata=%h exc=%b want 1 0 00",
                     i, resp_valid, resp_rdata, resp_exc);
         end
         cyc();
      end
   endtask

   task automatic test_misaligned();
      logic [2:0]  ops[3] = '{3'b100, 3'b110, 3'b010};
      logic [31:0] adr[3] = '{32'h4001, 32'h4001, 32'h4003};
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_op = ops[i];
         req_addr = adr[i];
         req_wdata = 32'h1111_2222;
         cyc();
         req_valid = 1'b0;
         tests++;
         if (resp_valid !== 1'b1 || resp_exc !== 2'b01 || resp_rdata !== 32'd0 ||
             mem_en !== 1'b0) begin
            fails++;
            $display("FAIL misalign_%0d: valid=%b exc=%b rdata=%h en=%b want 1 01 0 0",
                     i, resp_valid, resp_exc, resp_rdata, mem_en);
         end
         cyc();
         tests++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_en !== 1'b0) begin
            fails++;
            $display("FAIL misalign_done_%0d: valid=%b ready=%b en=%b want 0 1 0",
                     i, resp_valid, req_ready, mem_en);
         end
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      req_valid_to = 1'b1;
      req_op = 3'b100;
      req_addr = 32'h0000_8000;
      cyc();
      req_valid_to = 1'b0;
      for (int i = 0; i < 10 && mem_en_to === 1'b1; i++) begin
         n++;
         cyc();
      end
      tests++;
      if (n != 4) begin
         fails++;
         $display("FAIL timeout_len: en cycles=%0d want 4", n);
      end
      tests++;
      if (resp_valid_to !== 1'b1 || resp_exc_to !== 2'b10 || resp_rdata_to !== 32'd0) begin
         fails++;
         $display("FAIL timeout_resp: valid=%b exc=%b rdata=%h want 1 10 0",
                  resp_valid_to, resp_exc_to, resp_rdata_to);
      end
      cyc();
      req_valid_to = 1'b1;
      req_addr = 32'h0000_8004;
      cyc();
      req_valid_to = 1'b0;
      mem_rdata = 32'h0102_0304;
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      tests++;
      if (resp_valid_to !== 1'b1 || resp_exc_to !== 2'b00 || resp_rdata_to !== 32'h0102_0304) begin
         fails++;
         $display("FAIL timeout_next: valid=%b exc=%b rdata=%h want 1 00 01020304",
                  resp_valid_to, resp_exc_to, resp_rdata_to);
      end
      cyc();
      // ack landing on the last allowed cycle completes normally
      req_valid_to = 1'b1;
      req_addr = 32'h0000_800C;
      cyc();
      req_valid_to = 1'b0;
      mem_rdata = 32'h5555_AAAA;
      cyc();
      cyc();
      cyc();
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      tests++;
      if (resp_valid_to !== 1'b1 || resp_exc_to !== 2'b00 || resp_rdata_to !== 32'h5555_AAAA) begin
         fails++;
         $display("FAIL timeout_edge_ack: valid=%b exc=%b rdata=%h want 1 00 5555aaaa",
                  resp_valid_to, resp_exc_to, resp_rdata_to);
      end
      cyc();
   endtask

   task automatic test_reset_abort();
      bit quiet = 1'b1;
      req_valid = 1'b1;
      req_op = 3'b111;
      req_addr = 32'h0000_9000;
      req_wdata = 32'h1357_9BDF;
      cyc();
      req_valid = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      tests++;
      if (mem_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 ||
          mem_we !== 4'b0000) begin
         fails++;
         $display("FAIL rst_abort: en=%b ready=%b valid=%b we=%b want 0 1 0 0000",
                  mem_en, req_ready, resp_valid, mem_we);
      end
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (resp_valid !== 1'b0 || mem_en !== 1'b0 || req_ready !== 1'b1)
            quiet = 1'b0;
         cyc();
      end
      tests++;
      if (!quiet) begin
         fails++;
         $display("FAIL rst_late_ack: quiet=%b want 1", quiet);
      end
   endtask

   initial begin
      test_reset();
      test_lb_fast();
      test_lhu_slow();
      test_loads();
      test_stores();
      test_misaligned();
      test_timeout();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
